// File: rtl/fir_interp_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// 32 kHz -> 48 kHz polyphase interpolator.
package fir_interp_pkg;
    localparam int NPHASE = 3;
    localparam int DECIM  = 2;
    localparam int NTAPS  = 16;
    localparam int DW     = 24;
    localparam int CW     = 24;
    localparam int AW     = 52;
    localparam int PW     = 2;
    localparam int RAW    = 6;

    typedef enum logic [1:0] {
        WAIT_IN = 2'd0,
        MAC     = 2'd1,
        OUT     = 2'd2
    } state_e;

    // Clamp a wide signed value into the 24-bit output range.
    function automatic logic signed [DW-1:0] sat24(input logic signed [AW-1:0] v);
        logic [AW-DW:0] top;
        top = v[AW-1:DW-1];
        if (top == '0 || top == '1) begin
            return v[DW-1:0];
        end else if (v[AW-1]) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return {1'b0, {(DW-1){1'b1}}};
        end
    endfunction
endpackage

// File: rtl/fir_mac24.sv
// Signed 24x24 multiply into a 52-bit accumulator, followed by round-half-up,
// arithmetic shift and saturation to 24 bits.
module fir_mac24
    import fir_interp_pkg::*;
#(
    parameter int OUT_SHIFT = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [CW-1:0] coef_i,
    input  logic signed [DW-1:0] samp_i,
    output logic signed [DW-1:0] res_o
);
    localparam logic signed [AW-1:0] RND = AW'(1) << (OUT_SHIFT - 1);

    logic signed [CW+DW-1:0] prod_w;
    logic signed [AW-1:0]    prod_ext_w;
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    acc_d;
    logic signed [AW-1:0]    rnd_w;
    logic signed [AW-1:0]    shr_w;

    assign prod_w     = coef_i * samp_i;
    assign prod_ext_w = {{(AW-CW-DW){prod_w[CW+DW-1]}}, prod_w};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The accumulator only changes in MAC, so the result is stable throughout OUT.
    assign rnd_w = acc_q + RND;
    assign shr_w = rnd_w >>> OUT_SHIFT;
    assign res_o = sat24(shr_w);
endmodule

// File: rtl/fir_interp_32_48.sv
// L=3/M=2 polyphase interpolator: sample history, phase sequencing, coefficient
// ROM addressing and the one-MAC-per-clock control FSM.
module fir_interp_32_48
    import fir_interp_pkg::*;
#(
    parameter int NTAPS     = 16,
    parameter int OUT_SHIFT = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [RAW-1:0]       rom_addr,
    input  logic signed [CW-1:0] rom_data
);
    localparam int TW   = $clog2(NTAPS);
    localparam int CNTW = TW + 1;

    state_e               state_q;
    logic [PW-1:0]        ph_q;
    logic [PW-1:0]        ph_d;
    logic                 need_q;
    logic                 need_d;
    logic [PW:0]          ph_sum_w;
    logic [CNTW-1:0]      cnt_q;
    logic [RAW-1:0]       rom_addr_q;
    logic [RAW-1:0]       base_q_w;
    logic [RAW-1:0]       base_d_w;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic signed [DW-1:0] hist_q [NTAPS];
    logic signed [DW-1:0] hist_d [NTAPS];
    logic signed [DW-1:0] samp_q;
    logic                 shift_w;
    logic                 mac_clr_w;
    logic                 mac_en_w;

    assign shift_w  = (state_q == WAIT_IN) && in_valid;
    assign ph_sum_w = {1'b0, ph_q} + (PW+1)'(DECIM);
    assign need_d   = (ph_sum_w >= (PW+1)'(NPHASE));
    assign ph_d     = need_d ? PW'(ph_sum_w - (PW+1)'(NPHASE)) : ph_sum_w[PW-1:0];
    assign base_q_w = RAW'(ph_q) * RAW'(NTAPS);
    assign base_d_w = RAW'(ph_d) * RAW'(NTAPS);

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_d[gi] = in_data;
            end else begin : g_tail
                assign hist_d[gi] = hist_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (shift_w) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    // The sample is registered alongside the ROM read so both operands of tap t
    // arrive together one cycle after its address was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
        end else if (state_q == MAC) begin
            samp_q <= hist_q[cnt_q[TW-1:0]];
        end
    end

    assign mac_clr_w = (state_q == MAC) && (cnt_q == '0);
    assign mac_en_w  = (state_q == MAC) && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_IN;
            ph_q        <= '0;
            need_q      <= 1'b1;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_IN: begin
                    if (in_valid) begin
                        state_q    <= MAC;
                        need_q     <= 1'b0;
                        cnt_q      <= '0;
                        rom_addr_q <= base_q_w;
                        in_ready_q <= 1'b0;
                    end
                end
                MAC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q < CNTW'(NTAPS - 1)) begin
                        rom_addr_q <= base_q_w + RAW'(cnt_q) + RAW'(1);
                    end
                    if (cnt_q == CNTW'(NTAPS)) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        ph_q        <= ph_d;
                        need_q      <= need_d;
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        if (need_d) begin
                            state_q    <= WAIT_IN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q    <= MAC;
                            rom_addr_q <= base_d_w;
                        end
                    end
                end
                default: begin
                    state_q     <= WAIT_IN;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    fir_mac24 #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (mac_clr_w),
        .en_i   (mac_en_w),
        .coef_i (rom_data),
        .samp_i (samp_q),
        .res_o  (out_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_fir_interp_32_48.sv
// Randomized scoreboard bench for the 32k->48k interpolator with a
// direct-form polyphase reference model and a random coefficient ROM.
module tb_fir_interp_32_48;
    localparam int K_RAND  = 0;
    localparam int K_IMP   = 1;
    localparam int K_MAX   = 2;
    localparam int K_MIN   = 3;
    localparam int K_SMALL = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_data;
    logic [5:0]         rom_addr;
    logic signed [23:0] rom_data;

    logic signed [23:0] coef [48];
    logic signed [23:0] xs [$];
    logic signed [23:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int k_next = 0;
    int out_idx = 0;
    int cyc = 0;
    int last_hs = -1000;
    int sat_hi = 0;
    int sat_lo = 0;
    bit prev_ov = 0;
    bit stalled = 0;
    logic signed [23:0] stall_data;
    logic [5:0]         stall_addr;

    fir_interp_32_48 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data <= coef[rom_addr];
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output k uses phase (2k mod 3) once floor(2k/3)+1 inputs have arrived.
    function automatic logic signed [23:0] model_out(int k);
        int     p;
        int     n;
        longint acc;
        longint r;
        p   = (2 * k) % 3;
        n   = (2 * k) / 3 + 1;
        acc = 0;
        for (int t = 0; t < 16; t++) begin
            if (n - 1 - t >= 0) begin
                acc += longint'(coef[p*16+t]) * longint'(xs[n-1-t]);
            end
        end
        r = (acc + (longint'(1) << 21)) >>> 22;
        if (r > 64'sd8388607) return 24'sh7FFFFF;
        if (r < -64'sd8388608) return 24'sh800000;
        return 24'(r);
    endfunction

    function automatic logic signed [23:0] gen_sample(int kind, int idx);
        case (kind)
            K_IMP:   return (idx == 0) ? 24'sh400000 : 24'sh000000;
            K_MAX:   return 24'sh7FFFFF;
            K_MIN:   return 24'sh800000;
            K_SMALL: return 24'(int'($urandom_range(0, 8191)) - 4096);
            default: return 24'($urandom);
        endcase
    endfunction

    // Input-side monitor: record accepted samples and push every output they enable.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            xs.push_back(in_data);
            last_hs = cyc;
            while ((2 * k_next) / 3 + 1 == xs.size()) begin
                exp_q.push_back(model_out(k_next));
                k_next++;
            end
        end
    end

    // Output-side monitor: compare, check pacing, latency and stall stability.
    always @(negedge clk) begin
        logic signed [23:0] e;
        if (!rst_n) begin
            prev_ov = 0;
            stalled = 0;
        end else begin
            if (in_ready && out_valid) chk("ready_valid_exclusive", 1, 0);
            if (stalled) begin
                chk("stall_valid", longint'(out_valid), 1);
                chk("stall_data", longint'(out_data), longint'(stall_data));
                chk("stall_rom_addr", longint'(rom_addr), longint'(stall_addr));
            end
            if (out_valid && !prev_ov) chk("latency", cyc - last_hs, 18);
            if (out_valid && out_ready) begin
                chk("input_pacing", xs.size(), (2 * out_idx) / 3 + 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_data[%0d]", out_idx), longint'(out_data), longint'(e));
                    if (e == 24'sh7FFFFF && out_data == e) sat_hi++;
                    if (e == 24'sh800000 && out_data == e) sat_lo++;
                end
                out_idx++;
                last_hs = cyc;
                stalled = 0;
            end else if (out_valid) begin
                stalled    = 1;
                stall_data = out_data;
                stall_addr = rom_addr;
            end else begin
                stalled = 0;
            end
            prev_ov = out_valid;
        end
    end

    task automatic run_seg(input int kind, input int ninputs);
        int sent  = 0;
        int guard = 0;
        while (sent < ninputs && guard < 5000) begin
            out_ready = ($urandom_range(0, 9) != 0);
            if (in_ready) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = gen_sample(kind, sent);
                    sent++;
                end else begin
                    in_valid = 1'b0;
                    in_data  = 24'($urandom);
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 24'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < ninputs) chk("segment_timeout", sent, ninputs);
    endtask

    task automatic backpressure();
        int guard = 0;
        out_ready = 1'b0;
        while (!out_valid && guard < 500) begin
            in_valid = in_ready;
            in_data  = 24'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) chk("bp_wait_timeout", 0, 1);
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            in_data  = 24'($urandom);
            @(posedge clk); #1;
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_mac();
        int guard = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("rst_wait_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = 24'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        xs.delete();
        exp_q.delete();
        k_next  = 0;
        out_idx = 0;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_rom_addr", longint'(rom_addr), 0);
        chk("rst_out_data", longint'(out_data), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", longint'(in_ready), 1);
        chk("rst_hold_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int v;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i >= 32) v = int'($urandom_range(524288, 1048575));
            else         v = int'($urandom_range(0, 1048576)) - 524288;
            coef[i] = 24'(v);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_rom_addr", longint'(rom_addr), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_seg(K_IMP, 12);
        run_seg(K_RAND, 30);
        backpressure();
        run_seg(K_MAX, 20);
        run_seg(K_MIN, 20);
        run_seg(K_SMALL, 20);
        reset_mid_mac();
        run_seg(K_IMP, 12);
        run_seg(K_RAND, 30);

        out_ready = 1'b1;
        in_valid  = 1'b0;
        guard     = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        chk("sat_pos_seen", longint'(sat_hi > 0), 1);
        chk("sat_neg_seen", longint'(sat_lo > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
